// File: rtl/noc_pkg.sv
// Shared NoC packet definitions used by the PE, the injection queue and the router.
package noc_pkg;

    localparam int X_SIZE      = 2;
    localparam int Y_SIZE      = 2;
    localparam int DATA_WIDTH  = 240;
    localparam int TOTAL_WIDTH = X_SIZE + Y_SIZE + DATA_WIDTH;

    // Head-packet field positions: dest X in the low bits, dest Y above it, payload on top
    localparam int DEST_X_LSB  = 0;
    localparam int DEST_X_MSB  = X_SIZE - 1;
    localparam int DEST_Y_LSB  = X_SIZE;
    localparam int DEST_Y_MSB  = X_SIZE + Y_SIZE - 1;
    localparam int PAYLOAD_LSB = X_SIZE + Y_SIZE;
    localparam int PAYLOAD_MSB = TOTAL_WIDTH - 1;

    // Default injection queue depth
    localparam int INJ_DEPTH   = 4;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] payload;
        logic [Y_SIZE-1:0]     dest_y;
        logic [X_SIZE-1:0]     dest_x;
    } noc_pkt_t;

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO with valid/ready on both sides. Ready and valid come from
// the registered entry count only, so there is no combinational path from
// m_ready to s_ready and no empty-queue bypass.
module noc_sync_fifo #(
    parameter int WIDTH = noc_pkg::TOTAL_WIDTH,
    parameter int DEPTH = noc_pkg::INJ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             push;
    logic             pop;

    assign s_ready = (cnt != FULL_CNT);
    assign m_valid = (cnt != '0);
    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;
    assign m_data  = mem[rd_ptr];
    assign count   = cnt;

    // Packet storage; contents are only meaningful while counted, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/pe_inject_queue.sv
// Injection queue between a traffic-generator PE and its router's local port.
// Wraps the FIFO and keeps injection statistics for the traffic reports.
module pe_inject_queue #(
    parameter int X_SIZE      = noc_pkg::X_SIZE,
    parameter int Y_SIZE      = noc_pkg::Y_SIZE,
    parameter int DATA_WIDTH  = noc_pkg::DATA_WIDTH,
    parameter int TOTAL_WIDTH = X_SIZE + Y_SIZE + DATA_WIDTH,
    parameter int DEPTH       = noc_pkg::INJ_DEPTH,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [TOTAL_WIDTH-1:0] s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [TOTAL_WIDTH-1:0] m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [AW:0]            occupancy,
    output logic [AW:0]            max_occupancy,
    output logic [31:0]            enq_count,
    output logic [31:0]            deq_count,
    output logic [31:0]            stall_cycles
);

    logic        enq;
    logic        deq;
    logic        stall;
    logic [AW:0] occ_next;

    noc_sync_fifo #(
        .WIDTH (TOTAL_WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .count   (occupancy)
    );

    assign enq   = s_valid & s_ready;
    assign deq   = m_valid & m_ready;
    assign stall = s_valid & ~s_ready;

    // Occupancy after this edge, so the peak tracks the same cycle as the count
    always_comb begin
        occ_next = occupancy;
        case ({enq, deq})
            2'b10:   occ_next = occupancy + 1'b1;
            2'b01:   occ_next = occupancy - 1'b1;
            default: occ_next = occupancy;
        endcase
    end

    // Statistics counters and peak occupancy; 32-bit counters wrap freely
    always_ff @(posedge clk) begin
        if (!rstn) begin
            max_occupancy <= '0;
            enq_count     <= '0;
            deq_count     <= '0;
            stall_cycles  <= '0;
        end else begin
            if (occ_next > max_occupancy) begin
                max_occupancy <= occ_next;
            end
            if (enq) begin
                enq_count <= enq_count + 32'd1;
            end
            if (deq) begin
                deq_count <= deq_count + 32'd1;
            end
            if (stall) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pe_inject_queue.sv
// Self-checking bench for pe_inject_queue: directed sequences, a fill/drain
// vector table, and randomized traffic against a queue-based reference model.
module tb_pe_inject_queue;
    import noc_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int TW    = TOTAL_WIDTH;

    typedef logic [TW-1:0] pkt_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    pkt_t          s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    pkt_t          m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [AW:0]   occupancy;
    logic [AW:0]   max_occupancy;
    logic [31:0]   enq_count;
    logic [31:0]   deq_count;
    logic [31:0]   stall_cycles;

    pe_inject_queue #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .occupancy     (occupancy),
        .max_occupancy (max_occupancy),
        .enq_count     (enq_count),
        .deq_count     (deq_count),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a plain queue of packets plus event tallies
    pkt_t        mq[$];
    int unsigned m_enq, m_deq, m_stall, m_max;

    typedef struct {
        bit          sv;
        bit          mr;
        int unsigned pl;
        bit          exp_sr;
        bit          exp_mv;
        int unsigned exp_occ;
        int unsigned exp_pl;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_pkt(input string name, input pkt_t act, input pkt_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic pkt_t mk(input int x, input int y, input int unsigned pl);
        pkt_t p;
        p = '0;
        p[DEST_X_LSB +: X_SIZE] = x[X_SIZE-1:0];
        p[DEST_Y_LSB +: Y_SIZE] = y[Y_SIZE-1:0];
        p[PAYLOAD_LSB +: 32]    = pl;
        return p;
    endfunction

    function automatic pkt_t rnd_pkt();
        pkt_t p;
        p = '0;
        for (int k = 0; k < 7; k++) p[k*32 +: 32] = $urandom();
        p[224 +: 20] = 20'($urandom());
        return p;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_enq = 0; m_deq = 0; m_stall = 0; m_max = 0;
    endtask

    task automatic do_reset(input int n);
        rstn = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rstn = 1'b1;
        model_clear();
    endtask

    // Compare every DUT output against the reference model
    task automatic check_model();
        chk("s_ready", 32'(s_ready), 32'(mq.size() != DEPTH));
        chk("m_valid", 32'(m_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk_pkt("m_data", m_data, mq[0]);
        chk("occupancy", 32'(occupancy), 32'(mq.size()));
        chk("max_occupancy", 32'(max_occupancy), m_max);
        chk("enq_count", enq_count, m_enq);
        chk("deq_count", deq_count, m_deq);
        chk("stall_cycles", stall_cycles, m_stall);
    endtask

    // Drive one cycle of inputs, advance the model, then step past the edge
    task automatic advance(input bit sv, input pkt_t d, input bit mr);
        bit full, emp, en, de;
        s_valid = sv; s_data = d; m_ready = mr;
        full = (mq.size() == DEPTH);
        emp  = (mq.size() == 0);
        en   = sv && !full;
        de   = mr && !emp;
        if (de) void'(mq.pop_front());
        if (en) mq.push_back(d);
        if (en) m_enq++;
        if (de) m_deq++;
        if (sv && full) m_stall++;
        if (mq.size() > m_max) m_max = mq.size();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Fill/back-pressure then drain, expectations taken before each edge
        tbl[0]  = '{1, 0, 0, 1, 0, 0, 0};
        tbl[1]  = '{1, 0, 1, 1, 1, 1, 0};
        tbl[2]  = '{1, 0, 2, 1, 1, 2, 0};
        tbl[3]  = '{1, 0, 3, 1, 1, 3, 0};
        tbl[4]  = '{1, 0, 4, 0, 1, 4, 0};
        tbl[5]  = '{1, 0, 5, 0, 1, 4, 0};
        tbl[6]  = '{0, 1, 0, 0, 1, 4, 0};
        tbl[7]  = '{0, 1, 0, 1, 1, 3, 1};
        tbl[8]  = '{0, 1, 0, 1, 1, 2, 2};
        tbl[9]  = '{0, 1, 0, 1, 1, 1, 3};
        tbl[10] = '{0, 0, 0, 1, 0, 0, 0};

        model_clear();

        // Reset state
        do_reset(2);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_max_occ", 32'(max_occupancy), 32'd0);
        chk("rst_enq", enq_count, 32'd0);
        chk("rst_deq", deq_count, 32'd0);
        chk("rst_stall", stall_cycles, 32'd0);

        // Single packet, no bypass
        advance(1'b1, mk(1, 2, 32'h2A), 1'b0);
        chk("single_m_valid", 32'(m_valid), 32'd1);
        chk_pkt("single_m_data", m_data, mk(1, 2, 32'h2A));
        chk("single_occ", 32'(occupancy), 32'd1);
        advance(1'b0, '0, 1'b1);
        chk("single_occ_after", 32'(occupancy), 32'd0);
        chk("single_m_valid_after", 32'(m_valid), 32'd0);
        chk("single_enq", enq_count, 32'd1);
        chk("single_deq", deq_count, 32'd1);
        advance(1'b0, '0, 1'b0);

        // Fill/back-pressure table
        do_reset(1);
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("tbl%0d_s_ready", i), 32'(s_ready), 32'(tbl[i].exp_sr));
            chk($sformatf("tbl%0d_m_valid", i), 32'(m_valid), 32'(tbl[i].exp_mv));
            chk($sformatf("tbl%0d_occ", i), 32'(occupancy), tbl[i].exp_occ);
            if (tbl[i].exp_mv)
                chk_pkt($sformatf("tbl%0d_m_data", i), m_data, mk(0, 0, tbl[i].exp_pl));
            advance(tbl[i].sv, mk(0, 0, tbl[i].pl), tbl[i].mr);
        end
        chk("fill_stall", stall_cycles, 32'd2);
        chk("fill_max_occ", 32'(max_occupancy), 32'd4);
        chk("fill_enq", enq_count, 32'd4);
        chk("fill_deq", deq_count, 32'd4);

        // Full with simultaneous offer and accept
        do_reset(1);
        for (int i = 0; i < 4; i++) advance(1'b1, mk(3, 1, 100 + i), 1'b0);
        chk("full_s_ready", 32'(s_ready), 32'd0);
        chk("full_occ", 32'(occupancy), 32'd4);
        advance(1'b1, mk(3, 1, 104), 1'b1);
        chk("fullsim_occ", 32'(occupancy), 32'd3);
        chk("fullsim_s_ready", 32'(s_ready), 32'd1);
        chk("fullsim_enq", enq_count, 32'd4);
        chk("fullsim_deq", deq_count, 32'd1);
        chk_pkt("fullsim_head", m_data, mk(3, 1, 101));
        advance(1'b1, mk(3, 1, 104), 1'b0);
        chk("fullsim_occ_refill", 32'(occupancy), 32'd4);
        chk("fullsim_enq_refill", enq_count, 32'd5);
        check_model();

        // Streaming at one packet per cycle
        do_reset(1);
        for (int i = 0; i < 100; i++) begin
            check_model();
            if (i == 0) chk("stream_first_not_valid", 32'(m_valid), 32'd0);
            if (i == 1) chk("stream_first_valid", 32'(m_valid), 32'd1);
            chk("stream_occ_le1", 32'(occupancy <= 1), 32'd1);
            advance(1'b1, mk(i % 4, (i / 4) % 4, i), 1'b1);
        end
        advance(1'b0, '0, 1'b1);
        check_model();
        chk("stream_enq", enq_count, 32'd100);
        chk("stream_deq", deq_count, 32'd100);
        chk("stream_stall", stall_cycles, 32'd0);

        // Reset with packets in flight
        do_reset(1);
        for (int i = 0; i < 3; i++) advance(1'b1, mk(2, 3, 200 + i), 1'b0);
        chk("midrst_occ_before", 32'(occupancy), 32'd3);
        do_reset(1);
        chk("midrst_occ", 32'(occupancy), 32'd0);
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_max", 32'(max_occupancy), 32'd0);
        chk("midrst_enq", enq_count, 32'd0);
        chk("midrst_deq", deq_count, 32'd0);
        chk("midrst_stall", stall_cycles, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("midrst_no_ghost", 32'(m_valid), 32'd0);
            advance(1'b0, '0, 1'b1);
        end

        // Randomized traffic with varying offer/accept bias and sporadic resets
        do_reset(1);
        for (int c = 0; c < 1200; c++) begin
            int unsigned pv, pr;
            case ((c / 200) % 3)
                0:       begin pv = 80; pr = 30; end
                1:       begin pv = 30; pr = 80; end
                default: begin pv = 60; pr = 60; end
            endcase
            check_model();
            if ($urandom_range(0, 199) == 0) begin
                do_reset(1);
                check_model();
            end
            advance($urandom_range(0, 99) < pv, rnd_pkt(), $urandom_range(0, 99) < pr);
        end
        check_model();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_inject_queue.md
# pe_inject_queue

Packet injection queue between a NoC traffic-generator PE and the local input port of its router. Accepts head-addressed packets (dest X, dest Y, payload) from the PE over a valid/ready handshake, buffers up to DEPTH of them in strict FIFO order, and presents them to the router's local port. It also keeps injection statistics (occupancy, peak occupancy, enqueue/dequeue counts, back-pressure cycles) for the traffic reports.

## Interface
- X_SIZE, 2, width of destination X field (bits [X_SIZE-1:0])
- Y_SIZE, 2, width of destination Y field (bits [X_SIZE+Y_SIZE-1:X_SIZE])
- DATA_WIDTH, 240, payload width (bits above the address fields)
- TOTAL_WIDTH, X_SIZE+Y_SIZE+DATA_WIDTH, packet width
- DEPTH, 4, queue entries; power of two, >= 2
- AW, $clog2(DEPTH), pointer width
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- s_data  in  TOTAL_WIDTH  packet from PE
- s_valid  in  1  PE offers s_data
- s_ready  out  1  queue can accept this cycle
- m_data  out  TOTAL_WIDTH  head packet to router local port
- m_valid  out  1  head packet present
- m_ready  in  1  router accepts head this cycle
- occupancy  out  AW+1  current entry count
- max_occupancy  out  AW+1  peak occupancy since reset
- enq_count  out  32  packets accepted from PE
- deq_count  out  32  packets delivered to router
- stall_cycles  out  32  cycles with s_valid & !s_ready

## Operation
- Enqueue when s_valid & s_ready: write s_data at wr_ptr, wr_ptr+1 mod DEPTH.
- Dequeue when m_valid & m_ready: rd_ptr+1 mod DEPTH.
- s_ready = (occupancy != DEPTH); depends on registered state only, never on m_ready (no combinational ready path through the queue).
- m_valid = (occupancy != 0); m_data = mem[rd_ptr]; packet bits passed unmodified.
- Occupancy: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
- Full and m_ready=1: dequeue occurs, enqueue does not (s_ready already low); s_ready rises next cycle.
- Empty and s_valid=1: no bypass; packet visible on m_data the following cycle.
- max_occupancy updated to new occupancy when it exceeds current max.
- enq_count, deq_count, stall_cycles: 32-bit, wrap at 2^32.
- Ordering strictly FIFO; no drop, no duplication.
- Once m_valid is high, m_data stays stable until the dequeue cycle.
- Upstream PE rule: PE counts a packet sent on s_valid & s_ready in the same cycle; queue must accept exactly those packets.

## Timing
- Reset (rstn low at a clk edge): pointers, occupancy, max_occupancy, all counters -> 0; s_ready=1, m_valid=0 from that edge. Storage not reset; m_data meaningful only while m_valid=1.
- Reset mid-operation: all queued packets discarded, none emitted afterwards.
- Enqueue-to-m_valid latency: 1 cycle. Sustained throughput: 1 packet/cycle with m_ready held high.
- All statistics outputs registered, reflecting events up to the previous edge.

## Structure
- Shared package noc_pkg: X_SIZE, Y_SIZE, DATA_WIDTH, TOTAL_WIDTH, field LSB/MSB constants for dest X, dest Y, payload; shared with PE and router.
- Sub-module noc_sync_fifo: storage, pointers, occupancy, s_ready/m_valid. Top pe_inject_queue adds statistics counters and peak tracking.

## Test plan
- Reset: hold rstn=0 two cycles -> s_ready=1, m_valid=0, occupancy=0, all counters 0.
- Single packet: enqueue dest (1,2) payload 0x2A, m_ready=0 -> next cycle m_valid=1, m_data identical, occupancy=1; pulse m_ready -> occupancy=0, enq_count=deq_count=1.
- Fill/back-pressure (DEPTH=4): m_ready=0, s_valid held 6 cycles, payloads 0..5 -> payloads 0-3 accepted, s_ready=0 after 4th, stall_cycles=2, max_occupancy=4; drain -> output order 0,1,2,3.
- Full + simultaneous: at full, s_valid=1 and m_ready=1 -> one dequeue, no enqueue, occupancy=3; next cycle s_ready=1 and pending packet accepted, occupancy back to 4.
- Streaming: s_valid=m_ready=1 for 100 packets with incrementing payload -> first m_valid one cycle after first enqueue, one packet/cycle, occupancy <= 1, enq_count=deq_count=100, stall_cycles=0, order preserved.
- Reset mid-operation: occupancy=3, rstn=0 one cycle -> occupancy=0, m_valid=0, counters 0; no pre-reset packet appears on m_data with m_valid=1.
